// File: rtl/misr_sig.sv
// misr_sig: multiple-input signature register for the LBIST response path.
// Folds NUM_PATTERNS response words into a BITS-wide Galois-form signature,
// then freezes it with sig_valid high until the next start.
module misr_sig #(
  parameter int             BITS         = 8,
  parameter logic [BITS-1:0] POLY        = 8'h1D,
  parameter logic [BITS-1:0] SEED        = 8'h00,
  parameter int             NUM_PATTERNS = 16,
  parameter int             CNT_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [BITS-1:0] data_in,
  output logic [BITS-1:0] sig,
  output logic            sig_valid,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Counter value of the final word of a run; the counter stops here.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // One MISR step: shift left, fold the MSB back through the taps, mix in data.
  function automatic logic [BITS-1:0] misr_step(input logic [BITS-1:0] cur,
                                                input logic [BITS-1:0] word);
    logic [BITS-1:0] fb;
    fb = cur[BITS-1] ? POLY : {BITS{1'b0}};
    return {cur[BITS-2:0], 1'b0} ^ fb ^ word;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [BITS-1:0]  sig_r, sig_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             sig_valid_r, sig_valid_nxt_s;

  // Next-state, next-signature and next-count logic; start outranks in_valid.
  always_comb begin
    state_nxt_s     = state_r;
    sig_nxt_s       = sig_r;
    cnt_nxt_s       = cnt_r;
    if (start) begin
      state_nxt_s = COMPACT;
      sig_nxt_s   = SEED;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        COMPACT: begin
          if (in_valid) begin
            sig_nxt_s = misr_step(sig_r, data_in);
            if (cnt_r == LAST_CNT) begin
              state_nxt_s = DONE;
              cnt_nxt_s   = cnt_r;
            end else begin
              state_nxt_s = COMPACT;
              cnt_nxt_s   = cnt_r + CNT_ONE;
            end
          end else begin
            state_nxt_s = COMPACT;
          end
        end
        DONE: begin
          state_nxt_s = DONE;
        end
        default: begin
          state_nxt_s = IDLE;
          sig_nxt_s   = SEED;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
    // Status flags are derived from the upcoming state so they register in
    // the same edge as the transition.
    busy_nxt_s      = (state_nxt_s == COMPACT);
    sig_valid_nxt_s = (state_nxt_s == DONE);
  end

  // State, signature, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sig_r       <= SEED;
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      sig_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sig_r       <= sig_nxt_s;
      cnt_r       <= cnt_nxt_s;
      busy_r      <= busy_nxt_s;
      sig_valid_r <= sig_valid_nxt_s;
    end
  end

  assign sig       = sig_r;
  assign sig_valid = sig_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_misr_sig.sv
// tb_misr_sig: directed bench for misr_sig. dut_a (SEED=00, 4 patterns) is
// checked every cycle against a queue-based model; dut_b (SEED=80, 1 pattern)
// exercises the feedback path with literal expectations.
module tb_misr_sig;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] sig_a, sig_b;
  logic       sv_a, sv_b, busy_a, busy_b;

  always #5 clk = ~clk;

  misr_sig #(.BITS(8), .POLY(8'h1D), .SEED(8'h00), .NUM_PATTERNS(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .data_in(data_in),
    .sig(sig_a), .sig_valid(sv_a), .busy(busy_a)
  );

  misr_sig #(.BITS(8), .POLY(8'h1D), .SEED(8'h80), .NUM_PATTERNS(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .data_in(data_in),
    .sig(sig_b), .sig_valid(sv_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model of dut_a: 0 idle, 1 compacting, 2 done; q holds words accepted this run.
  int       mode = 0;
  int       q[$];

  // Signature is the polynomial fold of all accepted words starting from the seed.
  function automatic int fold();
    int s;
    s = 0;
    foreach (q[i]) begin
      s = ((s * 2) % 256) ^ ((s >= 128) ? 29 : 0) ^ q[i];
    end
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, then advance the model.
  task automatic cyc(input bit r, input bit s, input bit v, input int d);
    @(negedge clk);
    rst = r; start = s; in_valid = v; data_in = 8'(d);
    @(posedge clk);
    if (r) begin
      mode = 0;
      q.delete();
    end else if (s) begin
      mode = 1;
      q.delete();
    end else if (mode == 1 && v) begin
      q.push_back(d);
      if (q.size() == 4) mode = 2;
    end
  endtask

  // Every-cycle compare of dut_a against the model, just after the edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_sig", int'(sig_a), fold());
      check("model_busy", int'(busy_a), int'(mode == 1));
      check("model_sig_valid", int'(sv_a), int'(mode == 2));
    end
  end

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk_en = 1'b1;
    #2;
    check("reset_sig", int'(sig_a), 8'h00);
    check("reset_busy", int'(busy_a), 0);
    check("reset_valid", int'(sv_a), 0);
    check("reset_sig_b", int'(sig_b), 8'h80);

    // Feedback path on dut_b: 80 with word 00 -> 1D.
    cyc(0, 1, 0, 0);
    #2; check("b_start_busy", int'(busy_b), 1);
    cyc(0, 0, 1, 8'h00);
    #2;
    check("b_sig", int'(sig_b), 8'h1D);
    check("b_valid", int'(sv_b), 1);
    check("b_busy", int'(busy_b), 0);

    // Consecutive words 01..04 -> 01,00,03,02.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 8'h01); #2; check("t1_w1", int'(sig_a), 8'h01);
    cyc(0, 0, 1, 8'h02); #2; check("t1_w2", int'(sig_a), 8'h00);
    cyc(0, 0, 1, 8'h03); #2; check("t1_w3", int'(sig_a), 8'h03);
    check("t1_valid_early", int'(sv_a), 0);
    cyc(0, 0, 1, 8'h04); #2; check("t1_w4", int'(sig_a), 8'h02);
    check("t1_valid", int'(sv_a), 1);
    cyc(0, 0, 0, 0); #2; check("t1_hold", int'(sig_a), 8'h02);

    // Extra words after done are ignored; start drops sig_valid next cycle.
    cyc(0, 0, 1, 8'h55);
    cyc(0, 0, 1, 8'hAA); #2; check("t6_frozen", int'(sig_a), 8'h02);
    check("t6_cmp_match", int'(sig_a == 8'h02), 1);
    cyc(0, 1, 0, 0); #2;
    check("t6_valid_drop", int'(sv_a), 0);
    check("t6_busy", int'(busy_a), 1);
    check("t6_reseed", int'(sig_a), 8'h00);

    // Same words with gaps of 1..3 idle cycles.
    cyc(0, 0, 1, 8'h01);
    cyc(0, 0, 0, 8'h77); #2; check("t2_gap_busy", int'(busy_a), 1);
    cyc(0, 0, 1, 8'h02);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); #2; check("t2_gap_sig", int'(sig_a), 8'h00);
    cyc(0, 0, 1, 8'h03);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'hEE);
    #2; check("t2_gap3_valid", int'(sv_a), 0);
    check("t2_gap3_busy", int'(busy_a), 1);
    cyc(0, 0, 1, 8'h04); #2;
    check("t2_final", int'(sig_a), 8'h02);
    check("t2_valid", int'(sv_a), 1);

    // Restart mid-run with in_valid and FF in the same cycle.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 8'h01);
    cyc(0, 0, 1, 8'h02);
    cyc(0, 1, 1, 8'hFF); #2;
    check("t4_reseed", int'(sig_a), 8'h00);
    check("t4_busy", int'(busy_a), 1);
    cyc(0, 0, 1, 8'h01);
    cyc(0, 0, 1, 8'h02);
    cyc(0, 0, 1, 8'h03); #2; check("t4_no_early_done", int'(sv_a), 0);
    cyc(0, 0, 1, 8'h04); #2;
    check("t4_final", int'(sig_a), 8'h02);
    check("t4_valid", int'(sv_a), 1);

    // Reset mid-run aborts; words are ignored until start.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 8'h01);
    cyc(0, 0, 1, 8'h02);
    cyc(1, 0, 1, 8'h03); #2;
    check("t5_sig", int'(sig_a), 8'h00);
    check("t5_busy", int'(busy_a), 0);
    check("t5_valid", int'(sv_a), 0);
    cyc(0, 0, 1, 8'h33);
    cyc(0, 0, 1, 8'h44); #2;
    check("t5_ignored", int'(sig_a), 8'h00);
    check("t5_idle_busy", int'(busy_a), 0);

    // A full run after reset still works.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 8'h10);
    cyc(0, 0, 1, 8'h9C);
    cyc(0, 0, 1, 8'hC3);
    cyc(0, 0, 1, 8'h5A);
    cyc(0, 0, 0, 0);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
